sha256_msg_padder: RTL



---
 rtl/sha256_msg_padder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Turns a stream of 32-bit message words into whole 16-word SHA-256 chunks.
// Each chunk holds data words, the 0x80 terminator, zero fill and the 64-bit
// bit length. Words are byte-lane little-endian (message byte 0 in [7:0]).
// The length words are byte-swapped so the schedule's big-endian swap
// recovers the big-endian length.
//
// Handshake: an input word transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in S_DATA. An output word is
// presented for exactly one cycle with out_valid. Downstream cannot
// back-pressure inside a chunk. chunk_ready is sampled only where a new
// chunk would start (widx = 0).
//
// Optional build macro SHA256_PAD_TRACE_EN adds a simulation-only trace line
// for every emitted word. It does not change the synthesised logic.
module sha256_msg_padder #(
  parameter int CHUNK_WORDS = 16,
  parameter int LEN_W       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  input  logic        chunk_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        chunk_start,
  output logic        chunk_end,
  output logic        msg_done,
  output logic        busy
);

  localparam int WIDX_W = $clog2(CHUNK_WORDS);
  localparam logic [WIDX_W-1:0] IDX_FIRST   = '0;
  localparam logic [WIDX_W-1:0] IDX_LAST    = WIDX_W'(CHUNK_WORDS - 1);
  // Index of the last word before the two length words.
  localparam logic [WIDX_W-1:0] IDX_PRE_LEN = WIDX_W'(CHUNK_WORDS - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_D,
    S_PAD80,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } state_t;

  state_t            state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              chunk_start_q, chunk_start_d;
  logic              chunk_end_q, chunk_end_d;
  logic              msg_done_q, msg_done_d;

  logic              at_boundary;
  logic              accept;
  logic              gen_go;
  logic              emit;
  logic [2:0]        in_nbytes;
  logic [31:0]       last_word;
  logic [63:0]       bit_len;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign in_ready = (state_q == S_DATA);
  assign busy     = (state_q != S_IDLE);

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign chunk_start = chunk_start_q;
  assign chunk_end   = chunk_end_q;
  assign msg_done    = msg_done_q;

  // Bit length is the byte count times eight, truncated to 64 bits.
  assign bit_len = 64'(byte_cnt_q) << 3;

  // Emission qualifiers: data words need an accepted input; pad and zero
  // words may only open a new chunk when downstream has room for it.
  always_comb begin
    at_boundary = (widx_q == IDX_FIRST);
    accept      = (state_q == S_DATA) && in_valid;
    gen_go      = ((state_q == S_PAD80) || (state_q == S_ZERO)) &&
                  (!at_boundary || chunk_ready);
    emit        = accept || gen_go ||
                  (state_q == S_LEN_HI) || (state_q == S_LEN_LO);
  end

  // Final data word: keep the valid lanes, put 0x80 in the first unused
  // lane and clear the lanes above it.
  always_comb begin
    in_nbytes = 3'd4;
    if (in_last && (in_bytes != 2'd0)) begin
      in_nbytes = {1'b0, in_bytes};
    end
    case (in_bytes)
      2'd1:    last_word = {16'h0000, 8'h80, in_data[7:0]};
      2'd2:    last_word = {8'h00, 8'h80, in_data[15:0]};
      2'd3:    last_word = {8'h80, in_data[23:0]};
      default: last_word = in_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && chunk_ready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (in_valid) begin
          if (in_last) begin
            if (in_bytes == 2'd0) begin
              state_d = S_PAD80;
            end else if (widx_q == IDX_PRE_LEN) begin
              state_d = S_LEN_HI;
            end else begin
              state_d = S_ZERO;
            end
          end else if ((widx_q == IDX_LAST) && !chunk_ready) begin
            state_d = S_WAIT_D;
          end
        end
      end
      S_WAIT_D: begin
        if (chunk_ready) begin
          state_d = S_DATA;
        end
      end
      S_PAD80: begin
        if (gen_go) begin
          state_d = (widx_q == IDX_PRE_LEN) ? S_LEN_HI : S_ZERO;
        end
      end
      S_ZERO: begin
        if (gen_go && (widx_q == IDX_PRE_LEN)) begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: state_d = S_LEN_LO;
      S_LEN_LO: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    out_valid_d   = emit;
    out_data_d    = 32'h0000_0000;
    chunk_start_d = emit && (widx_q == IDX_FIRST);
    chunk_end_d   = emit && (widx_q == IDX_LAST);
    msg_done_d    = 1'b0;
    widx_d        = emit ? widx_q + WIDX_W'(1) : widx_q;
    byte_cnt_d    = accept ? byte_cnt_q + LEN_W'(in_nbytes) : byte_cnt_q;
    case (state_q)
      S_DATA: begin
        if (accept) begin
          out_data_d = in_last ? last_word : in_data;
        end
      end
      S_PAD80: begin
        if (gen_go) begin
          out_data_d = 32'h0000_0080;
        end
      end
      S_LEN_HI: begin
        out_data_d = bswap(bit_len[63:32]);
      end
      S_LEN_LO: begin
        out_data_d = bswap(bit_len[31:0]);
        msg_done_d = 1'b1;
        byte_cnt_d = '0;
      end
      default: begin
        out_data_d = 32'h0000_0000;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      widx_q        <= '0;
      byte_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'h0000_0000;
      chunk_start_q <= 1'b0;
      chunk_end_q   <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      widx_q        <= widx_d;
      byte_cnt_q    <= byte_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      chunk_start_q <= chunk_start_d;
      chunk_end_q   <= chunk_end_d;
      msg_done_q    <= msg_done_d;
    end
  end

`ifdef SHA256_PAD_TRACE_EN
  // Trace every word as it is registered for output.
  always_ff @(posedge clk) begin
    if (!rst && !clear && emit) begin
      $display("%m t=%0t widx=%0d state=%s data=%08h",
               $time, widx_q, state_q.name(), out_data_d);
    end
  end
`endif

endmodule
